// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the clock display path: segment glyphs,
// scan state encoding and default scan timing.
package clock_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_P     = 7'b0011000;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam int DEF_NUM_DIGITS   = 8;
  localparam int DEF_REFRESH_DIV  = 100000;
  localparam int DEF_DEAD_CYCLES  = 16;
  localparam int DEF_BLINK_FRAMES = 125;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan timebase: slot counter, digit index, frame counter and blink phase.
// Emits single-cycle strobes for the edge that wraps a slot and the edge that ends dead time.
module scan_prescaler
  import clock_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int DEAD_CYCLES  = DEF_DEAD_CYCLES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [$clog2(NUM_DIGITS)-1:0] o_idx,
  output logic                          o_slot_wrap,
  output logic                          o_drive_start,
  output logic                          o_blink_phase
);

  localparam int SLOT_W  = cnt_width(REFRESH_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int FRAME_W = cnt_width(BLINK_FRAMES);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]  DEAD_LAST  = SLOT_W'(DEAD_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0]  r_slot_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_blink_phase;

  logic w_slot_wrap;
  logic w_frame_wrap;
  logic w_blink_wrap;

  assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
  assign w_frame_wrap = w_slot_wrap && (r_idx == IDX_LAST);
  // Frame wrap and blink wrap coincide on one edge: a single toggle, a single reset.
  assign w_blink_wrap = w_frame_wrap && (r_frame_cnt == FRAME_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_slot_cnt    <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
      if (w_slot_wrap) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      if (w_frame_wrap) begin
        r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + 1'b1;
      end
      if (w_blink_wrap) begin
        r_blink_phase <= ~r_blink_phase;
      end
    end
  end

  assign o_idx         = r_idx;
  assign o_slot_wrap   = w_slot_wrap;
  assign o_drive_start = (r_slot_cnt == DEAD_LAST);
  assign o_blink_phase = r_blink_phase;

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with anti-ghosting dead time,
// per-slot input capture and field blinking.
module display_scan_ctrl
  import clock_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int DEAD_CYCLES  = DEF_DEAD_CYCLES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en_i,
  input  logic [7*NUM_DIGITS-1:0]       digit_seg_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  input  logic [NUM_DIGITS-1:0]         blink_mask_i,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic [6:0]                    seg_o,
  output logic                          dp_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [IDX_W-1:0] w_idx;
  logic             w_slot_wrap;
  logic             w_drive_start;
  logic             w_blink_phase;

  scan_prescaler #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_prescaler (
    .clk          (clk),
    .reset        (reset),
    .o_idx        (w_idx),
    .o_slot_wrap  (w_slot_wrap),
    .o_drive_start(w_drive_start),
    .o_blink_phase(w_blink_phase)
  );

  logic [6:0] w_seg_arr [NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg_split
      assign w_seg_arr[gi] = digit_seg_i[7*gi +: 7];
    end
  endgenerate

  scan_state_t r_state;
  logic [6:0]  r_cap_seg;
  logic        r_cap_dp;
  logic        r_cap_blink;
  logic        r_cap_phase;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  // The output registers load on the capture edge itself, so the effective
  // captured values are the live inputs on that edge and the held copy afterwards.
  logic [6:0]            w_seg_cur;
  logic                  w_dp_cur;
  logic                  w_hide_cur;
  logic                  w_drive_next;
  logic [NUM_DIGITS-1:0] w_an_drive;

  assign w_seg_cur    = w_drive_start ? w_seg_arr[w_idx] : r_cap_seg;
  assign w_dp_cur     = w_drive_start ? dp_i[w_idx] : r_cap_dp;
  assign w_hide_cur   = w_drive_start ? (blink_mask_i[w_idx] && w_blink_phase)
                                      : (r_cap_blink && r_cap_phase);
  assign w_drive_next = w_drive_start || ((r_state == DRIVE) && !w_slot_wrap);
  assign w_an_drive   = ~(NUM_DIGITS'(1) << w_idx);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= BLANK;
      r_cap_seg   <= SEG_BLANK;
      r_cap_dp    <= 1'b0;
      r_cap_blink <= 1'b0;
      r_cap_phase <= 1'b0;
      r_an        <= '1;
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b1;
    end else begin
      case (r_state)
        BLANK: begin
          if (w_drive_start) begin
            r_state     <= DRIVE;
            r_cap_seg   <= w_seg_arr[w_idx];
            r_cap_dp    <= dp_i[w_idx];
            r_cap_blink <= blink_mask_i[w_idx];
            r_cap_phase <= w_blink_phase;
          end
        end
        DRIVE: begin
          if (w_slot_wrap) begin
            r_state <= BLANK;
          end
        end
        default: r_state <= BLANK;
      endcase

      if (w_drive_next && en_i) begin
        r_an  <= w_an_drive;
        r_seg <= w_hide_cur ? SEG_BLANK : w_seg_cur;
        r_dp  <= w_hide_cur ? 1'b1 : ~w_dp_cur;
      end else begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end
    end
  end

  assign an_o        = r_an;
  assign seg_o       = r_seg;
  assign dp_o        = r_dp;
  assign digit_idx_o = w_idx;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: cycle-count reference model checked
// every clock, table vectors, hand-written corner sequences and random stimulus.
module tb_display_scan_ctrl;
  import clock_disp_pkg::*;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          en_i;
  logic [7*ND-1:0] digit_seg_i;
  logic [ND-1:0] dp_i;
  logic [ND-1:0] blink_mask_i;
  logic [ND-1:0] an_o;
  logic [6:0]    seg_o;
  logic          dp_o;
  logic [1:0]    digit_idx_o;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en_i        (en_i),
    .digit_seg_i (digit_seg_i),
    .dp_i        (dp_i),
    .blink_mask_i(blink_mask_i),
    .an_o        (an_o),
    .seg_o       (seg_o),
    .dp_o        (dp_o),
    .digit_idx_o (digit_idx_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model state: edges since the last reset edge, plus what the current slot latched.
  int         t = 0;
  logic [6:0] m_seg = SEG_BLANK;
  logic       m_dp = 1'b0;
  logic       m_blink = 1'b0;
  logic       m_phase = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, t);
  endtask

  task automatic tick();
    logic          rs, en_s;
    logic [7*ND-1:0] ds;
    logic [ND-1:0] dps, bms;
    logic [ND-1:0] e_an;
    logic [6:0]    e_seg;
    logic          e_dp;
    int            sc, ix;
    rs = reset; en_s = en_i; ds = digit_seg_i; dps = dp_i; bms = blink_mask_i;
    @(posedge clk);
    #1;
    t  = rs ? t + 1 : 0;
    sc = t % RD;
    ix = (t / RD) % ND;
    if (rs && sc == DC) begin
      m_seg   = ds[7*ix +: 7];
      m_dp    = dps[ix];
      m_blink = bms[ix];
      m_phase = ((t / (RD * ND * BF)) % 2) == 1;
    end
    e_an = '1; e_seg = SEG_BLANK; e_dp = 1'b1;
    if (rs && sc >= DC && en_s) begin
      e_an = ~(4'b0001 << ix);
      if (!(m_blink && m_phase)) begin
        e_seg = m_seg;
        e_dp  = ~m_dp;
      end
    end
    chk("model_an", an_o, e_an);
    chk("model_seg", seg_o, e_seg);
    chk("model_dp", dp_o, e_dp);
    chk("model_idx", digit_idx_o, ix);
    chk("one_cold", ($countones(~an_o) <= 1), 1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic [7*ND-1:0] segs;
    logic [ND-1:0]   dp;
    logic [ND-1:0]   mask;
    logic            en;
    int              t_at;
    logic [ND-1:0]   e_an;
    logic [6:0]      e_seg;
    logic            e_dp;
  } vec_t;

  vec_t vec [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{{SEG_P, SEG_A, SEG_A, SEG_A}, 4'b0000, 4'b0000, 1'b1, 28, 4'b0111, SEG_P, 1'b1};
    vec[1] = '{{SEG_P, SEG_A, SEG_A, SEG_A}, 4'b0000, 4'b0000, 1'b1, 4, 4'b1110, SEG_A, 1'b1};
    vec[2] = '{{SEG_A, SEG_BLANK, 7'h12, 7'h40}, 4'b0100, 4'b0000, 1'b1, 20, 4'b1011, SEG_BLANK, 1'b0};
    vec[3] = '{{SEG_A, SEG_BLANK, 7'h12, 7'h40}, 4'b0100, 4'b0000, 1'b1, 12, 4'b1101, 7'h12, 1'b1};
    vec[4] = '{{SEG_A, SEG_BLANK, 7'h12, 7'h40}, 4'b0100, 4'b0000, 1'b0, 12, 4'b1111, SEG_BLANK, 1'b1};
    vec[5] = '{{SEG_A, SEG_BLANK, 7'h12, 7'h40}, 4'b0100, 4'b1111, 1'b1, 4, 4'b1110, 7'h40, 1'b1};
    vec[6] = '{{SEG_A, SEG_BLANK, 7'h12, 7'h40}, 4'b0100, 4'b0100, 1'b1, 84, 4'b1011, SEG_BLANK, 1'b1};

    reset = 1'b0; en_i = 1'b1;
    digit_seg_i = {SEG_A, SEG_A, SEG_A, SEG_A};
    dp_i = '0; blink_mask_i = '0;

    // Reset and release timing
    do_reset(3);
    tick(); chk("rel_t1_an", an_o, 4'hF);
    tick(); chk("rel_t2_an", an_o, 4'b1110);
    chk("rel_t2_seg", seg_o, SEG_A);
    repeat (6) tick(); chk("rel_idx_adv", digit_idx_o, 1);
    $display("seq reset_release done t=%0d", t);

    for (int i = 0; i < 7; i++) begin
      reset = 1'b0;
      digit_seg_i = vec[i].segs; dp_i = vec[i].dp;
      blink_mask_i = vec[i].mask; en_i = vec[i].en;
      repeat (2) tick();
      reset = 1'b1;
      repeat (vec[i].t_at) tick();
      chk("vec_an", an_o, vec[i].e_an);
      chk("vec_seg", seg_o, vec[i].e_seg);
      chk("vec_dp", dp_o, vec[i].e_dp);
      $display("vector %0d: t=%0d an=%b seg=%b dp=%b", i, t, an_o, seg_o, dp_o);
    end

    // Mid-slot input change must not tear slot 0
    en_i = 1'b1; dp_i = '0; blink_mask_i = '0;
    digit_seg_i = {SEG_A, SEG_A, SEG_A, SEG_A};
    do_reset(2);
    repeat (4) tick();
    digit_seg_i[6:0] = SEG_P;
    tick(); chk("tear_t5", seg_o, SEG_A);
    repeat (2) tick(); chk("tear_t7", seg_o, SEG_A);
    repeat (29) tick(); chk("tear_next_seg", seg_o, SEG_P);
    chk("tear_next_an", an_o, 4'b1110);
    $display("seq midslot_capture done t=%0d", t);

    // Display disable mid-frame keeps the scan running
    en_i = 1'b0;
    tick(); chk("en_off_an", an_o, 4'hF);
    repeat (19) tick(); chk("en_off_idx", digit_idx_o, 3);
    en_i = 1'b1;
    repeat (4) tick(); chk("en_resume_an", an_o, 4'b0111);
    $display("seq enable_gap done t=%0d", t);

    // Reset during DRIVE in the hidden blink phase restarts at phase 0
    digit_seg_i = {SEG_A, SEG_A, SEG_A, SEG_A};
    blink_mask_i = 4'b0100;
    do_reset(2);
    repeat (84) tick();
    chk("prerst_an", an_o, 4'b1011);
    chk("prerst_seg", seg_o, SEG_BLANK);
    reset = 1'b0;
    tick();
    chk("rst_an", an_o, 4'hF);
    chk("rst_idx", digit_idx_o, 0);
    reset = 1'b1;
    repeat (20) tick();
    chk("postrst_an", an_o, 4'b1011);
    chk("postrst_seg", seg_o, SEG_A);
    $display("seq reset_mid_drive done t=%0d", t);

    // Random traffic against the reference model
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) digit_seg_i = 28'($urandom);
      if ($urandom_range(0, 7) == 0) dp_i = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask_i = 4'($urandom);
      en_i  = ($urandom_range(0, 15) != 0);
      reset = ($urandom_range(0, 299) != 0);
      tick();
    end
    $display("seq random done t=%0d", t);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
